// File: rtl/sw_io_pkg.sv
// Shared switch-I/O definitions: the LSU-facing switch word type and the
// debounce defaults used by sw_debounce.
package sw_io_pkg;

    localparam int SW_WORD_W         = 32;
    localparam int TICK_DIV_DEF      = 50000;  // 1 ms at 50 MHz
    localparam int STABLE_TICKS_DEF  = 8;

    // Word seen by the LSU on its switch-address read path.
    typedef logic [SW_WORD_W-1:0] io_sw_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch lane: two-flop synchroniser, tick-qualified stability counter,
// debounced state flop, and registered output with matching edge pulses.
module sw_debounce_bit #(
    parameter int STABLE_TICKS = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic raw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [1:0]    sync_pipe;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          stable;

    assign sync = sync_pipe[1];

    // Bring the asynchronous level into the clock domain.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[0], raw_i};
    end

    // Flip only after STABLE_TICKS consecutive ticks of disagreement;
    // any agreement in between restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (tick_i) begin
            if (cnt == CNT_LAST) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Output register; pulses land in the same cycle the new level appears.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_o   <= 1'b0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            sw_o   <= stable;
            rise_o <= stable & ~sw_o;
            fall_o <= ~stable & sw_o;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning ahead of the LSU switch port: per-bit debounce lanes
// sharing one free-running sample prescaler.
// Optional sticky change interrupt enabled by defining SW_DEBOUNCE_IRQ_EN.
module sw_debounce
    import sw_io_pkg::*;
#(
    parameter int NUM_SW       = 18,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_SW-1:0]    sw_raw_i,
    output logic [SW_WORD_W-1:0] io_sw_o,
    output logic [NUM_SW-1:0]    sw_rise_o,
    output logic [NUM_SW-1:0]    sw_fall_o,
    output logic                 sw_irq_o,
    input  logic                 sw_irq_clr_i
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]     pre;
    logic              tick;
    logic [NUM_SW-1:0] sw_q;
    io_sw_t            io_word;

    assign tick = (pre == PRE_LAST);

    // Free-running sample prescaler; input activity never restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i)     pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .tick_i (tick),
            .raw_i  (sw_raw_i[i]),
            .sw_o   (sw_q[i]),
            .rise_o (sw_rise_o[i]),
            .fall_o (sw_fall_o[i])
        );
    end

    // Zero-extend the debounced lanes into the LSU switch word.
    always_comb begin
        io_word               = '0;
        io_word[NUM_SW-1:0]   = sw_q;
    end

    assign io_sw_o = io_word;

`ifdef SW_DEBOUNCE_IRQ_EN
    // Sticky change flag; a new event wins over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i)                          sw_irq_o <= 1'b0;
        else if (|sw_rise_o || |sw_fall_o)  sw_irq_o <= 1'b1;
        else if (sw_irq_clr_i)              sw_irq_o <= 1'b0;
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = sw_irq_clr_i;
    assign sw_irq_o       = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce at NUM_SW=4, TICK_DIV=4, STABLE_TICKS=3.
// Clean-edge latency window is 12..15 cycles; with the prescaler phase fixed
// by reset and the raw level present at release, the flip lands on cycle 13.
module tb_sw_debounce;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  sw_raw_i = 4'h0;
    logic        sw_irq_clr_i = 1'b0;
    logic [31:0] io_sw_o;
    logic [3:0]  sw_rise_o;
    logic [3:0]  sw_fall_o;
    logic        sw_irq_o;

    int checks = 0;
    int errors = 0;

    sw_debounce #(
        .NUM_SW       (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sw_raw_i     (sw_raw_i),
        .io_sw_o      (io_sw_o),
        .sw_rise_o    (sw_rise_o),
        .sw_fall_o    (sw_fall_o),
        .sw_irq_o     (sw_irq_o),
        .sw_irq_clr_i (sw_irq_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        int n;
        bit early;
        rst_i    = 1'b1;
        sw_raw_i = 4'hF;
        repeat (5) step();
        checks++;
        if (io_sw_o !== 32'h0) begin errors++; $display("FAIL reset_io got %h exp %h", io_sw_o, 32'h0); end
        checks++;
        if (sw_rise_o !== 4'h0 || sw_fall_o !== 4'h0) begin
            errors++; $display("FAIL reset_pulse got rise %h fall %h exp 0 0", sw_rise_o, sw_fall_o);
        end
        checks++;
        if (sw_irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", sw_irq_o); end
        rst_i = 1'b0;
        n = 99;
        early = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (io_sw_o !== 32'h0) begin n = c; break; end
            if (sw_rise_o !== 4'h0) early = 1'b1;
        end
        checks++;
        if (n != 13) begin errors++; $display("FAIL reset_latency got %0d exp 13", n); end
        checks++;
        if (io_sw_o !== 32'h0000000F) begin errors++; $display("FAIL reset_io_after got %h exp %h", io_sw_o, 32'hF); end
        checks++;
        if (sw_rise_o !== 4'hF || early) begin
            errors++; $display("FAIL reset_rise got %h early %b exp F 0", sw_rise_o, early);
        end
        step();
        checks++;
        if (sw_rise_o !== 4'h0) begin errors++; $display("FAIL reset_rise_width got %h exp 0", sw_rise_o); end
    endtask

    task automatic test_glitch();
        bit bad;
        int n;
        rst_i    = 1'b1;
        sw_raw_i = 4'h0;
        repeat (2) step();
        rst_i    = 1'b0;
        sw_raw_i = 4'h1;
        bad      = 1'b0;
        for (int c = 0; c < 36; c++) begin
            if (c == 6) sw_raw_i = 4'h0;
            step();
            if (io_sw_o !== 32'h0 || sw_rise_o !== 4'h0 || sw_fall_o !== 4'h0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL glitch_reject got io %h exp 0", io_sw_o); end
        // A leftover count would shorten this qualification.
        sw_raw_i = 4'h1;
        n = 99;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (io_sw_o !== 32'h0) begin n = c; break; end
        end
        checks++;
        if (n < 12 || n > 15) begin errors++; $display("FAIL glitch_requal got %0d exp 12..15", n); end
        checks++;
        if (io_sw_o !== 32'h1 || sw_rise_o !== 4'h1) begin
            errors++; $display("FAIL glitch_after got io %h rise %h exp 1 1", io_sw_o, sw_rise_o);
        end
    endtask

    task automatic test_bounce();
        int rises;
        int falls;
        int n;
        rises = 0;
        falls = 0;
        n = 99;
        for (int k = 0; k < 20; k++) begin
            if (k % 3 == 0) sw_raw_i[2] = ~sw_raw_i[2];
            step();
            rises += int'(sw_rise_o[2]);
            falls += int'(sw_fall_o[2]);
        end
        // Last toggle (to 1) happened at k=18, two edges ago.
        for (int c = 3; c <= 30; c++) begin
            step();
            rises += int'(sw_rise_o[2]);
            falls += int'(sw_fall_o[2]);
            if (io_sw_o[2] === 1'b1 && n == 99) n = c;
        end
        checks++;
        if (n < 12 || n > 15) begin errors++; $display("FAIL bounce_latency got %0d exp 12..15", n); end
        checks++;
        if (rises != 1 || falls != 0) begin
            errors++; $display("FAIL bounce_pulses got rise %0d fall %0d exp 1 0", rises, falls);
        end
    endtask

    task automatic test_fall_simul();
        int n;
        checks++;
        if (io_sw_o !== 32'h5) begin errors++; $display("FAIL simul_start got %h exp %h", io_sw_o, 32'h5); end
        sw_raw_i = 4'hA;
        n = 99;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (io_sw_o !== 32'h5) begin n = c; break; end
        end
        checks++;
        if (n < 12 || n > 15) begin errors++; $display("FAIL simul_latency got %0d exp 12..15", n); end
        checks++;
        if (io_sw_o !== 32'hA) begin errors++; $display("FAIL simul_io got %h exp %h", io_sw_o, 32'hA); end
        checks++;
        if (sw_rise_o !== 4'hA || sw_fall_o !== 4'h5) begin
            errors++; $display("FAIL simul_pulses got rise %h fall %h exp A 5", sw_rise_o, sw_fall_o);
        end
        step();
        checks++;
        if (sw_rise_o !== 4'h0 || sw_fall_o !== 4'h0) begin
            errors++; $display("FAIL simul_width got rise %h fall %h exp 0 0", sw_rise_o, sw_fall_o);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        int n;
        rst_i    = 1'b1;
        sw_raw_i = 4'h0;
        repeat (2) step();
        rst_i    = 1'b0;
        sw_raw_i = 4'h2;
        bad      = 1'b0;
        // Ticks at edges 4 and 8 leave bit1 one tick short of flipping.
        repeat (9) begin
            step();
            if (io_sw_o !== 32'h0 || sw_rise_o !== 4'h0) bad = 1'b1;
        end
        rst_i = 1'b1;
        step();
        if (io_sw_o !== 32'h0 || sw_rise_o !== 4'h0) bad = 1'b1;
        rst_i = 1'b0;
        n = 99;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (io_sw_o !== 32'h0) begin n = c; break; end
            if (sw_rise_o !== 4'h0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL midreset_hold got io %h exp 0", io_sw_o); end
        checks++;
        if (n != 13) begin errors++; $display("FAIL midreset_requal got %0d exp 13", n); end
        checks++;
        if (io_sw_o !== 32'h2 || sw_rise_o !== 4'h2) begin
            errors++; $display("FAIL midreset_after got io %h rise %h exp 2 2", io_sw_o, sw_rise_o);
        end
    endtask

    task automatic test_irq();
        bit seen;
        rst_i        = 1'b1;
        sw_raw_i     = 4'h0;
        sw_irq_clr_i = 1'b0;
        repeat (2) step();
        rst_i    = 1'b0;
        sw_raw_i = 4'h1;
`ifdef SW_DEBOUNCE_IRQ_EN
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (sw_rise_o[0] === 1'b1) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || sw_irq_o !== 1'b0) begin
            errors++; $display("FAIL irq_pre got seen %b irq %b exp 1 0", seen, sw_irq_o);
        end
        step();
        checks++;
        if (sw_irq_o !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", sw_irq_o); end
        sw_irq_clr_i = 1'b1;
        step();
        sw_irq_clr_i = 1'b0;
        checks++;
        if (sw_irq_o !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", sw_irq_o); end
        sw_raw_i = 4'h0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (sw_fall_o[0] === 1'b1) begin seen = 1'b1; break; end
        end
        sw_irq_clr_i = 1'b1;
        step();
        checks++;
        if (!seen || sw_irq_o !== 1'b1) begin
            errors++; $display("FAIL irq_set_prio got seen %b irq %b exp 1 1", seen, sw_irq_o);
        end
        step();
        sw_irq_clr_i = 1'b0;
        checks++;
        if (sw_irq_o !== 1'b0) begin errors++; $display("FAIL irq_clr2 got %b exp 0", sw_irq_o); end
`else
        seen = 1'b0;
        for (int c = 0; c < 24; c++) begin
            sw_irq_clr_i = c[0];
            step();
            if (sw_irq_o !== 1'b0) seen = 1'b1;
        end
        sw_irq_clr_i = 1'b0;
        checks++;
        if (seen) begin errors++; $display("FAIL irq_tied got 1 exp 0"); end
        checks++;
        if (io_sw_o !== 32'h1) begin errors++; $display("FAIL irq_io got %h exp %h", io_sw_o, 32'h1); end
`endif
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_bounce();
        test_fall_simul();
        test_reset_mid();
        test_irq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
